// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath.
// master = sequencer side, slave = datapath side.
interface mips_multicycle_control_if #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] IN;
  logic                zero;
  logic                mem_ready;

  logic                PCwrite;
  logic                PCwritecond;
  logic                IorD;
  logic                IRwrite;
  logic                MR;
  logic                MW;
  logic                Regwrite;
  logic                ALUsrcA;
  logic [1:0]          RegDst;
  logic [1:0]          Memtoreg;
  logic [1:0]          ALUsrcB;
  logic [1:0]          ALUop;
  logic [1:0]          PCsrc;
  logic                illegal;
  logic                instr_done;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  IN, mem_ready,
    output PCwrite, PCwritecond, IorD, IRwrite, MR, MW, Regwrite, ALUsrcA,
           RegDst, Memtoreg, ALUsrcB, ALUop, PCsrc, illegal, instr_done, retired
  );

  modport slave (
    output IN, zero, mem_ready,
    input  PCwrite, PCwritecond, IorD, IRwrite, MR, MW, Regwrite, ALUsrcA,
           RegDst, Memtoreg, ALUsrcB, ALUop, PCsrc, illegal, instr_done, retired
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath: 3-5 cycles per instruction,
// optional memory wait states, illegal-opcode pulse and retired-instruction counter.
module mips_multicycle_control #(
  parameter int OPCODE_W      = 6,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mips_multicycle_control_if.master   bus
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JR    = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(8);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ,
    MEM_WB, MEM_WRITE, BRANCH, JUMP, JAL, JR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             rdy;
  logic             done;

  // With the handshake disabled every memory access completes in one cycle.
  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_q + CNT_W'(done);
    end
  end

  assign bus.retired    = retired_q;
  assign bus.instr_done = done;

  always_comb begin
    state_d         = state_q;
    done            = 1'b0;
    bus.PCwrite     = 1'b0;
    bus.PCwritecond = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRwrite     = 1'b0;
    bus.MR          = 1'b0;
    bus.MW          = 1'b0;
    bus.Regwrite    = 1'b0;
    bus.ALUsrcA     = 1'b0;
    bus.RegDst      = 2'b00;
    bus.Memtoreg    = 2'b00;
    bus.ALUsrcB     = 2'b00;
    bus.ALUop       = 2'b00;
    bus.PCsrc       = 2'b00;
    bus.illegal     = 1'b0;

    case (state_q)
      FETCH: begin
        bus.MR      = 1'b1;
        bus.ALUsrcB = 2'b01;
        bus.IRwrite = rdy;
        bus.PCwrite = rdy;
        if (rdy) state_d = DECODE;
      end
      DECODE: begin
        bus.ALUsrcB = 2'b11;
        case (bus.IN)
          OP_RTYPE:        state_d = EXEC_R;
          OP_ADDI, OP_SLTI: state_d = EXEC_I;
          OP_LW, OP_SW:    state_d = MEM_ADDR;
          OP_J:            state_d = JUMP;
          OP_JAL:          state_d = JAL;
          OP_JR:           state_d = JR;
          OP_BEQ:          state_d = BRANCH;
          default: begin
            bus.illegal = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUop   = 2'b10;
        state_d     = ALU_WB;
      end
      EXEC_I: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = 2'b10;
        bus.ALUop   = (bus.IN == OP_SLTI) ? 2'b11 : 2'b00;
        state_d     = ALU_WB;
      end
      ALU_WB: begin
        bus.Regwrite = 1'b1;
        bus.RegDst   = (bus.IN == OP_RTYPE) ? 2'b01 : 2'b00;
        done         = 1'b1;
        state_d      = FETCH;
      end
      MEM_ADDR: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = 2'b10;
        // An opcode that changed after DECODE abandons the access.
        if (bus.IN == OP_LW)      state_d = MEM_READ;
        else if (bus.IN == OP_SW) state_d = MEM_WRITE;
        else                      state_d = FETCH;
      end
      MEM_READ: begin
        bus.IorD = 1'b1;
        bus.MR   = 1'b1;
        if (rdy) state_d = MEM_WB;
      end
      MEM_WB: begin
        bus.Regwrite = 1'b1;
        bus.Memtoreg = 2'b01;
        done         = 1'b1;
        state_d      = FETCH;
      end
      MEM_WRITE: begin
        bus.IorD = 1'b1;
        bus.MW   = rdy;
        done     = rdy;
        if (rdy) state_d = FETCH;
      end
      BRANCH: begin
        bus.ALUsrcA     = 1'b1;
        bus.ALUop       = 2'b01;
        bus.PCsrc       = 2'b01;
        bus.PCwritecond = 1'b1;
        done            = 1'b1;
        state_d         = FETCH;
      end
      JUMP: begin
        bus.PCsrc   = 2'b10;
        bus.PCwrite = 1'b1;
        done        = 1'b1;
        state_d     = FETCH;
      end
      JAL: begin
        bus.PCsrc    = 2'b10;
        bus.PCwrite  = 1'b1;
        bus.RegDst   = 2'b10;
        bus.Memtoreg = 2'b10;
        bus.Regwrite = 1'b1;
        done         = 1'b1;
        state_d      = FETCH;
      end
      JR: begin
        bus.PCsrc   = 2'b11;
        bus.PCwrite = 1'b1;
        done        = 1'b1;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control: each instruction is expanded into its
// per-cycle step list and every cycle's outputs are compared with the expected decode.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       PCwrite;
    logic       PCwritecond;
    logic       IorD;
    logic       IRwrite;
    logic       MR;
    logic       MW;
    logic       Regwrite;
    logic       ALUsrcA;
    logic [1:0] RegDst;
    logic [1:0] Memtoreg;
    logic [1:0] ALUsrcB;
    logic [1:0] ALUop;
    logic [1:0] PCsrc;
    logic       illegal;
    logic       instr_done;
  } outs_t;

  typedef enum int {
    ST_F, ST_D, ST_ER, ST_EI, ST_WB, ST_MA, ST_MR, ST_MWB, ST_MW,
    ST_BR, ST_J, ST_JAL, ST_JR
  } step_e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] model_cnt = '0;

  mips_multicycle_control_if #(.OPCODE_W(6), .CNT_W(32)) bus ();
  mips_multicycle_control_if #(.OPCODE_W(6), .CNT_W(4))  bus4 ();

  assign bus4.IN        = bus.IN;
  assign bus4.zero      = bus.zero;
  assign bus4.mem_ready = bus.mem_ready;

  mips_multicycle_control #(.OPCODE_W(6), .MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mips_multicycle_control #(.OPCODE_W(6), .MEM_HANDSHAKE(1'b1), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  outs_t got, got4;
  assign got  = {bus.PCwrite, bus.PCwritecond, bus.IorD, bus.IRwrite, bus.MR, bus.MW,
                 bus.Regwrite, bus.ALUsrcA, bus.RegDst, bus.Memtoreg, bus.ALUsrcB,
                 bus.ALUop, bus.PCsrc, bus.illegal, bus.instr_done};
  assign got4 = {bus4.PCwrite, bus4.PCwritecond, bus4.IorD, bus4.IRwrite, bus4.MR, bus4.MW,
                 bus4.Regwrite, bus4.ALUsrcA, bus4.RegDst, bus4.Memtoreg, bus4.ALUsrcB,
                 bus4.ALUop, bus4.PCsrc, bus4.illegal, bus4.instr_done};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected control lines for one cycle of a given instruction step.
  function automatic outs_t expect_outs(step_e s, logic [5:0] op, logic rdy);
    outs_t e;
    e = '0;
    case (s)
      ST_F:   begin e.MR = 1'b1; e.ALUsrcB = 2'b01; e.IRwrite = rdy; e.PCwrite = rdy; end
      ST_D:   begin e.ALUsrcB = 2'b11; e.illegal = (op > 6'd8); end
      ST_ER:  begin e.ALUsrcA = 1'b1; e.ALUop = 2'b10; end
      ST_EI:  begin e.ALUsrcA = 1'b1; e.ALUsrcB = 2'b10; e.ALUop = (op == 6'd2) ? 2'b11 : 2'b00; end
      ST_WB:  begin e.Regwrite = 1'b1; e.RegDst = (op == 6'd0) ? 2'b01 : 2'b00; e.instr_done = 1'b1; end
      ST_MA:  begin e.ALUsrcA = 1'b1; e.ALUsrcB = 2'b10; end
      ST_MR:  begin e.IorD = 1'b1; e.MR = 1'b1; end
      ST_MWB: begin e.Regwrite = 1'b1; e.Memtoreg = 2'b01; e.instr_done = 1'b1; end
      ST_MW:  begin e.IorD = 1'b1; e.MW = rdy; e.instr_done = rdy; end
      ST_BR:  begin e.ALUsrcA = 1'b1; e.ALUop = 2'b01; e.PCsrc = 2'b01; e.PCwritecond = 1'b1; e.instr_done = 1'b1; end
      ST_J:   begin e.PCsrc = 2'b10; e.PCwrite = 1'b1; e.instr_done = 1'b1; end
      ST_JAL: begin e.PCsrc = 2'b10; e.PCwrite = 1'b1; e.RegDst = 2'b10; e.Memtoreg = 2'b10;
                    e.Regwrite = 1'b1; e.instr_done = 1'b1; end
      ST_JR:  begin e.PCsrc = 2'b11; e.PCwrite = 1'b1; e.instr_done = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_cycle(input step_e s, input logic [5:0] in_v, input logic rdy);
    outs_t e;
    bus.IN        = in_v;
    bus.mem_ready = rdy;
    @(negedge clk);
    e = expect_outs(s, in_v, rdy);
    check(s.name(), 64'(got), 64'(e));
    check({s.name(), "_w4"}, 64'(got4), 64'(e));
    check("retired", 64'(bus.retired), 64'(model_cnt));
    check("retired_w4", 64'(bus4.retired), 64'(model_cnt & 32'hF));
    if (e.instr_done) model_cnt = model_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [5:0] op, input int wf, input int wr, input int ww);
    for (int i = 0; i < wf; i++) run_cycle(ST_F, 6'($urandom), 1'b0);
    run_cycle(ST_F, 6'($urandom), 1'b1);
    run_cycle(ST_D, op, 1'($urandom));
    case (op)
      6'd0: begin run_cycle(ST_ER, op, 1'($urandom)); run_cycle(ST_WB, op, 1'($urandom)); end
      6'd1, 6'd2: begin run_cycle(ST_EI, op, 1'($urandom)); run_cycle(ST_WB, op, 1'($urandom)); end
      6'd3: begin
        run_cycle(ST_MA, op, 1'($urandom));
        for (int i = 0; i < wr; i++) run_cycle(ST_MR, op, 1'b0);
        run_cycle(ST_MR, op, 1'b1);
        run_cycle(ST_MWB, op, 1'($urandom));
      end
      6'd4: begin
        run_cycle(ST_MA, op, 1'($urandom));
        for (int i = 0; i < ww; i++) run_cycle(ST_MW, op, 1'b0);
        run_cycle(ST_MW, op, 1'b1);
      end
      6'd5: run_cycle(ST_J, op, 1'($urandom));
      6'd6: run_cycle(ST_JAL, op, 1'($urandom));
      6'd7: run_cycle(ST_JR, op, 1'($urandom));
      6'd8: run_cycle(ST_BR, op, 1'($urandom));
      default: ;
    endcase
  endtask

  // Entered just after a rising edge; reset is asserted there and released one edge later.
  task automatic async_reset();
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    model_cnt = '0;
    check("rst_outs", 64'(got), 64'(expect_outs(ST_F, 6'd0, 1'b1)));
    check("rst_regwrite", 64'(bus.Regwrite), 64'd0);
    check("rst_retired", 64'(bus.retired), 64'd0);
    check("rst_retired_w4", 64'(bus4.retired), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] op;
    bus.IN        = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    check("por_outs_rdy1", 64'(got), 64'(expect_outs(ST_F, 6'd0, 1'b1)));
    check("por_retired", 64'(bus.retired), 64'd0);
    bus.mem_ready = 1'b0;
    #1;
    check("por_outs_rdy0", 64'(got), 64'(expect_outs(ST_F, 6'd0, 1'b0)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_instr(6'd0, 0, 0, 0);
    do_instr(6'd3, 0, 0, 0);
    check("retired_after_r_lw", 64'(bus.retired), 64'd2);
    do_instr(6'd4, 0, 0, 3);
    do_instr(6'd8, 2, 0, 0);
    do_instr(6'd6, 0, 0, 0);
    do_instr(6'd7, 0, 0, 0);
    do_instr(6'd3, 1, 2, 0);
    do_instr(6'd1, 0, 0, 0);
    do_instr(6'd2, 0, 0, 0);
    do_instr(6'h3F, 0, 0, 0);
    do_instr(6'd9, 0, 0, 0);
    check("retired_directed", 64'(bus.retired), 64'd9);

    // Abandon an R-type in EXEC_R, then confirm the next instruction is clean.
    run_cycle(ST_F, 6'd0, 1'b1);
    run_cycle(ST_D, 6'd0, 1'b1);
    async_reset();
    do_instr(6'd0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 11) > 8) op = 6'($urandom_range(9, 63));
      else                           op = 6'($urandom_range(0, 8));
      do_instr(op, int'($urandom_range(0, 3)) - 1 > 0 ? 1 : 0,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    @(posedge clk);
    #1;
    async_reset();
    for (int n = 0; n < 17; n++) do_instr(6'd5, 0, 0, 0);
    check("wrap_w4", 64'(bus4.retired), 64'd1);
    check("jumps_w32", 64'(bus.retired), 64'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
